// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU wrapper: ALU op codes,
// major opcodes and the funct3 values that decode to supported operations.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_ctrl.sv
// Combinational decode of opcode/funct3/funct7[5] into the 3-bit ALU op,
// an R-type flag and an illegal-instruction flag.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] op,
  output logic       is_r,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    op      = OP_ADD;
    illegal = 1'b0;
    is_r    = (opcode == OPC_R);

    case (funct3)
      F3_ADD:  op = (is_r && funct7b5) ? OP_SUB : OP_ADD;
      F3_AND:  op = OP_AND;
      F3_OR:   op = OP_OR;
      F3_SLT:  op = OP_SLT;
      default: illegal = 1'b1;
    endcase

    if (!is_r && (opcode != OPC_I))
      illegal = 1'b1;

    // Undecodable instructions still flow down the pipe as a harmless ADD.
    if (illegal)
      op = OP_ADD;
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/retire stage around the combinational ALU with RAW hazard handling.
// Define ALU_FWD_EN to replace RAW stalls with operand bypass from X and W.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [RAW-1:0]  in_rs1,
  input  logic [RAW-1:0]  in_rs2,
  input  logic [RAW-1:0]  in_rd,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            flush,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RAW-1:0]  out_rd,
  output logic [XLEN-1:0] out_res,
  output logic            out_zero,
  output logic            out_we,
  output logic            illegal
);

  logic           x_valid;
  logic           x_we;
  logic [RAW-1:0] x_rd;

  logic [2:0]      dec_op;
  logic            dec_is_r;
  logic            dec_illegal;
  logic            dec_we;
  logic            w_free;
  logic            accept;
  logic            hazard;
  logic            match_x1, match_x2, match_w1, match_w2;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_b;

  alu_ctrl u_ctrl (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .op       (dec_op),
    .is_r     (dec_is_r),
    .illegal  (dec_illegal)
  );

  // x_we/out_we are never set for rd = 0, so x0 sources cannot match.
  assign match_x1 = x_valid && x_we && (x_rd == in_rs1);
  assign match_w1 = out_valid && out_we && (out_rd == in_rs1);
  assign match_x2 = dec_is_r && x_valid && x_we && (x_rd == in_rs2);
  assign match_w2 = dec_is_r && out_valid && out_we && (out_rd == in_rs2);

`ifdef ALU_FWD_EN
  assign hazard  = 1'b0;
  assign rs1_fwd = match_x1 ? alu_res : (match_w1 ? out_res : in_rs1_val);
  assign rs2_fwd = match_x2 ? alu_res : (match_w2 ? out_res : in_rs2_val);
`else
  assign hazard  = match_x1 || match_w1 || match_x2 || match_w2;
  assign rs1_fwd = in_rs1_val;
  assign rs2_fwd = in_rs2_val;
`endif

  assign op_b     = dec_is_r ? rs2_fwd : in_imm;
  assign dec_we   = !dec_illegal && (in_rd != '0);
  assign w_free   = !out_valid || out_ready;
  assign in_ready = !flush && !hazard && (!x_valid || w_free);
  assign accept   = in_valid && in_ready;

  // Stage X: issue register feeding the ALU directly; data holds when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset as well because they drive module outputs that must read 0 after reset.
    if (!rst_n) begin
      x_valid <= 1'b0;
      x_we    <= 1'b0;
      x_rd    <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= OP_ADD;
      illegal <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      illegal <= accept && dec_illegal;
      if (flush) begin
        x_valid <= 1'b0;
      end else if (accept) begin
        x_valid <= 1'b1;
        x_we    <= dec_we;
        x_rd    <= in_rd;
        alu_a   <= rs1_fwd;
        alu_b   <= op_b;
        alu_op  <= dec_op;
      end else if (x_valid && w_free) begin
        x_valid <= 1'b0;
      end
    end
  end

  // Stage W: retire register; a flush in the same cycle discards the X entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_res   <= '0;
      out_zero  <= 1'b0;
      out_we    <= 1'b0;
    end else if (w_free) begin
      out_valid <= x_valid && !flush;
      if (x_valid && !flush) begin
        out_rd   <= x_rd;
        out_res  <= alu_res;
        out_zero <= alu_zero;
        out_we   <= x_we;
      end
    end
  end

endmodule
